i2c_master_arbiter: RTL
=======================

Name: i2c_master_arbiter

Overview:
- Shares one I2C master engine between N_REQ requesters using round-robin arbitration.
- Latches the winning requester's address, direction and write data, then releases the master from reset for exactly one transaction.
- Waits for the master's done pulse, or a timeout, and returns read data plus a status pulse to the winning requester.
- Sits between the requester ports and the master engine's rst/wr/addr/din/done/datard pins, in the same scl clock domain.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, scl cycles allowed in RUN before a transaction is declared failed (>= 32).
- GAP_CYCLES, 2, cycles m_rst is held high between transactions (>= 1).

Ports:
- scl  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- req_wr  input  N_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  input  7*N_REQ  per-requester 7-bit target address; requester i uses bits [7i+6:7i].
- req_din  input  8*N_REQ  per-requester write byte; requester i uses bits [8i+7:8i].
- gnt  output  N_REQ  one-hot grant, high for the whole transaction.
- rsp_valid  output  N_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  output  1  qualifies rsp_valid; 1 = timeout.
- rsp_rdata  output  8  read byte; valid with rsp_valid.
- busy  output  1  high whenever state != IDLE.
- m_rst  output  1  master reset; 1 holds the master idle.
- m_wr  output  1  master direction.
- m_addr  output  7  master address.
- m_din  output  8  master write byte.
- m_done  input  1  master completion flag.
- m_rdata  input  8  master read byte.

Behaviour:
- Reset values:
  - m_rst = 1.
  - gnt, rsp_valid, rsp_err, rsp_rdata, m_wr, m_addr, m_din, busy = 0.
  - Round-robin pointer ptr = 0; timeout counter = 0; state = IDLE.
- Reset mid-transaction: all outputs return to reset values on the next edge; no rsp_valid is issued.
- States: IDLE, RUN, GAP.
- IDLE, cycle t with req != 0:
  - Select the first set bit searching ptr, ptr+1, ... modulo N_REQ.
  - At edge t+1: gnt[idx] = 1; m_wr/m_addr/m_din are loaded from idx's fields; m_rst = 0; counter = 0; go to RUN.
  - Grant latency is 1 cycle.
- IDLE with req == 0: stay; m_rst stays 1.
- Requester fields are sampled only at grant. Changes afterwards are ignored, and m_* stay stable through RUN.
- RUN, counter increments every cycle:
  - m_done == 1: rsp_rdata <= m_rdata (read), or 0 for a write; rsp_err <= 0; rsp_valid[idx] <= 1 for one cycle; gnt <= 0; m_rst <= 1; ptr <= (idx+1) mod N_REQ; go to GAP.
  - Otherwise, counter == TIMEOUT-1: same as above but rsp_err <= 1 and rsp_rdata <= 0.
  - m_done and timeout in the same cycle: done wins, rsp_err = 0.
- Dropping req while granted does not abort; the response is still issued.
- GAP: m_rst held 1 for GAP_CYCLES cycles, counted from the cycle after the response edge. Requests are not evaluated during GAP. Then go to IDLE.
- rsp_err and rsp_rdata hold their values until the next response.
- Width rules:
  - Counter width is clog2(TIMEOUT+1); it saturates and never wraps within RUN.
  - ptr width is clog2(N_REQ), minimum 1.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.

Test Plan:
1. Write, requester 0: req[0] = 1, wr = 1, addr = 0x50, din = 0xA5; model master asserts m_done 22 cycles after m_rst falls.
   -> gnt = 01 one cycle after req; m_addr = 0x50, m_wr = 1, m_din = 0xA5 stable through RUN; rsp_valid = 01 for 1 cycle; rsp_err = 0; m_rst = 1 for 2 cycles before IDLE.
2. Read, requester 1: req[1] = 1, wr = 0, addr = 0x3C; model returns m_rdata = 0x5A with m_done.
   -> rsp_valid = 10, rsp_rdata = 0x5A, rsp_err = 0.
3. Contention: req = 11 held from reset for 4 transactions.
   -> grant order 0,1,0,1; never two gnt bits high at once.
4. Timeout: granted read, m_done never asserted.
   -> exactly 64 RUN cycles after grant: rsp_valid pulse, rsp_err = 1, rsp_rdata = 0x00, m_rst = 1; next request still served.
5. Reset mid-transaction: rst asserted at RUN cycle 10.
   -> next edge: gnt = 0, m_rst = 1, busy = 0, no rsp_valid; then req[1] alone is granted with ptr = 0 search.
6. Simultaneous events: m_done asserted on the cycle counter == TIMEOUT-1.
   -> rsp_err = 0 and rsp_rdata = m_rdata.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between N_REQ requesters.
// Each grant runs exactly one transaction, ending on m_done or timeout, followed by a reset gap.
module i2c_master_arbiter #(
  parameter int N_REQ      = 2,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic               scl,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_wr,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_din,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic               rsp_err,
  output logic [7:0]         rsp_rdata,
  output logic               busy,
  output logic               m_rst,
  output logic               m_wr,
  output logic [6:0]         m_addr,
  output logic [7:0]         m_din,
  input  logic               m_done,
  input  logic [7:0]         m_rdata
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] sel;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;

  // Later assignments win: wrap-around candidates first, then ptr..N_REQ-1 in priority order.
  always_comb begin
    sel = ptr;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (req[j] && (PW'(j) < ptr)) sel = PW'(j);
    for (int j = N_REQ - 1; j >= 0; j--)
      if (req[j] && (PW'(j) >= ptr)) sel = PW'(j);
  end

  always_ff @(posedge scl) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      m_rst     <= 1'b1;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_din     <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (req != '0) begin
            idx    <= sel;
            gnt    <= ONE << sel;
            m_wr   <= req_wr[sel];
            m_addr <= req_addr[7*sel +: 7];
            m_din  <= req_din[8*sel +: 8];
            m_rst  <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          // m_done takes precedence over a coincident timeout
          if (m_done || (cnt == CNT_LAST)) begin
            rsp_err   <= !m_done;
            rsp_rdata <= (m_done && !m_wr) ? m_rdata : 8'h00;
            rsp_valid <= gnt;
            gnt       <= '0;
            m_rst     <= 1'b1;
            ptr       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
